// File: rtl/hamm_secded_decoder.sv
`default_nettype none
// ============================================================================
// Module      : hamm_secded_decoder
// Description : Two-stage pipelined Hamming SECDED decoder with valid/ready
//               handshaking. Optional saturating error counters are built
//               when HAMM_ERR_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module hamm_secded_decoder #(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 16,
  localparam int PAR_W  = (DATA_W + 4 <= 8)  ? 3 :
                          (DATA_W + 5 <= 16) ? 4 :
                          (DATA_W + 6 <= 32) ? 5 : 6,
  localparam int CW_W   = DATA_W + PAR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err_corr,
`ifdef HAMM_ERR_CNT_EN
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr,
`endif
  output logic              out_err_uncorr
);

  // Hamming position holding data bit k: the k-th non-power-of-two index >= 3.
  function automatic int data_pos(input int k);
    int cnt;
    data_pos = 0;
    cnt      = 0;
    for (int i = 3; i < 128; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (cnt == k) data_pos = i;
        cnt++;
      end
    end
  endfunction

  logic              en;
  logic [PAR_W-1:0]  syn_in;
  logic [DATA_W-1:0] raw_in;

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [PAR_W-1:0]  s1_syn;
  logic              s1_par;

  logic              flip;
  logic              corr;
  logic              uncorr;
  logic [DATA_W-1:0] fixed_data;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  always_comb begin
    syn_in = '0;
    for (int i = 1; i < CW_W; i++) begin
      if (in_code[i]) syn_in = syn_in ^ PAR_W'(i);
    end
  end

  // Check bits are fully summarised by the syndrome and overall parity, so
  // only the data field of the codeword travels down the pipe.
  for (genvar k = 0; k < DATA_W; k++) begin : g_data
    localparam int POS = data_pos(k);
    assign raw_in[k]     = in_code[POS];
    assign fixed_data[k] = s1_data[k] ^ (flip && (s1_syn == PAR_W'(POS)));
  end

  always_comb begin
    flip   = 1'b0;
    corr   = 1'b0;
    uncorr = 1'b0;
    if (s1_syn == '0) begin
      corr = s1_par;
    end else if (!s1_par || (int'(s1_syn) > CW_W - 1)) begin
      uncorr = 1'b1;
    end else begin
      corr = 1'b1;
      flip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid       <= 1'b0;
      s1_data        <= '0;
      s1_syn         <= '0;
      s1_par         <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_err_corr   <= 1'b0;
      out_err_uncorr <= 1'b0;
    end else if (en) begin
      s1_valid       <= in_valid;
      s1_data        <= raw_in;
      s1_syn         <= syn_in;
      s1_par         <= ^in_code;
      out_valid      <= s1_valid;
      out_data       <= fixed_data;
      out_err_corr   <= corr && s1_valid;
      out_err_uncorr <= uncorr && s1_valid;
    end
  end

`ifdef HAMM_ERR_CNT_EN
  logic out_fire;
  assign out_fire = out_valid && out_ready;

  // Clear takes priority over a coincident increment; counts stick at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (clr_cnt) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else begin
      if (out_fire && out_err_corr && (cnt_corr != '1))
        cnt_corr <= cnt_corr + CNT_W'(1);
      if (out_fire && out_err_uncorr && (cnt_uncorr != '1))
        cnt_uncorr <= cnt_uncorr + CNT_W'(1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hamm_secded_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_hamm_secded_decoder
// Description : Directed plus randomized bench for hamm_secded_decoder with a
//               codeword-level reference decoder and in-order scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hamm_secded_decoder;
  localparam int DATA_W  = 4;
  localparam int CW_W    = 8;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              corr;
    logic              uncorr;
  } res_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [CW_W-1:0]   in_code;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_err_corr;
  logic              out_err_uncorr;
`ifdef HAMM_ERR_CNT_EN
  logic              clr_cnt;
  logic [CNT_W-1:0]  cnt_corr;
  logic [CNT_W-1:0]  cnt_uncorr;
  int                m_corr;
  int                m_uncorr;
`endif

  int                vectors     = 0;
  int                miscompares = 0;
  res_t              exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  logic              accepted;
  logic              hold_pending;
  res_t              held;

  hamm_secded_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_code        (in_code),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_err_corr   (out_err_corr),
`ifdef HAMM_ERR_CNT_EN
    .clr_cnt        (clr_cnt),
    .cnt_corr       (cnt_corr),
    .cnt_uncorr     (cnt_uncorr),
`endif
    .out_err_uncorr (out_err_uncorr)
  );

  always #5 clk = ~clk;

  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] c;
    int k, s;
    c = '0;
    k = 0;
    s = 0;
    for (int pos = 1; pos < CW_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[k];
        if (d[k]) s = s ^ pos;
        k++;
      end
    end
    for (int j = 0; (1 << j) < CW_W; j++) c[1 << j] = s[j];
    c[0] = ^c;
    return c;
  endfunction

  function automatic res_t ref_decode(input logic [CW_W-1:0] c);
    logic [CW_W-1:0] f;
    res_t r;
    int s, p, k;
    s = 0;
    p = 0;
    f = c;
    for (int i = 0; i < CW_W; i++) begin
      if (c[i]) begin
        p = p ^ 1;
        if (i > 0) s = s ^ i;
      end
    end
    r.corr   = 1'b0;
    r.uncorr = 1'b0;
    if (p == 1 && s == 0) r.corr = 1'b1;
    else if (p == 1 && s < CW_W) begin
      r.corr = 1'b1;
      f[s]   = ~f[s];
    end else if (s != 0) r.uncorr = 1'b1;
    k = 0;
    r.data = '0;
    for (int pos = 1; pos < CW_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        r.data[k] = f[pos];
        k++;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes away from the edge, then advance to edge+1.
  task automatic tick();
    res_t e;
    logic have_e;
    logic fire;
    accepted = 1'b0;
    have_e   = 1'b0;
    e        = '0;
    #3;
    if (hold_pending) begin
      check("hold_valid",  32'(out_valid),      32'd1);
      check("hold_data",   32'(out_data),       32'(held.data));
      check("hold_corr",   32'(out_err_corr),   32'(held.corr));
      check("hold_uncorr", 32'(out_err_uncorr), 32'(held.uncorr));
    end
    hold_pending = out_valid && !out_ready;
    held.data    = out_data;
    held.corr    = out_err_corr;
    held.uncorr  = out_err_uncorr;
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_decode(in_code));
      accepted = 1'b1;
    end
    fire = out_valid && out_ready;
    if (fire) begin
      got_q.push_back(out_data);
      check("expected_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        have_e = 1'b1;
        check("sb_data",   32'(out_data),       32'(e.data));
        check("sb_corr",   32'(out_err_corr),   32'(e.corr));
        check("sb_uncorr", 32'(out_err_uncorr), 32'(e.uncorr));
      end
    end
`ifdef HAMM_ERR_CNT_EN
    if (clr_cnt) begin
      m_corr   = 0;
      m_uncorr = 0;
    end else if (fire && have_e) begin
      if (e.corr && m_corr < CNT_MAX) m_corr++;
      if (e.uncorr && m_uncorr < CNT_MAX) m_uncorr++;
    end
`endif
    @(posedge clk);
    #1;
`ifdef HAMM_ERR_CNT_EN
    check("cnt_corr",   32'(cnt_corr),   32'(m_corr));
    check("cnt_uncorr", 32'(cnt_uncorr), 32'(m_uncorr));
`endif
  endtask

  task automatic single(input string tag, input logic [CW_W-1:0] code,
                        input logic [DATA_W-1:0] d, input logic c, input logic u);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = code;
    tick();
    in_valid = 1'b0;
    check({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    tick();
    check({tag, "_lat2_valid"}, 32'(out_valid),      32'd1);
    check({tag, "_data"},       32'(out_data),       32'(d));
    check({tag, "_corr"},       32'(out_err_corr),   32'(c));
    check({tag, "_uncorr"},     32'(out_err_uncorr), 32'(u));
    tick();
  endtask

  task automatic drain();
    int n;
    n         = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      tick();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] d;
    logic [CW_W-1:0]   mask;
    int                b1, b2, nerr;

    reset        = 1'b1;
    in_valid     = 1'b0;
    in_code      = '0;
    out_ready    = 1'b1;
    hold_pending = 1'b0;
    held         = '0;
`ifdef HAMM_ERR_CNT_EN
    clr_cnt  = 1'b0;
    m_corr   = 0;
    m_uncorr = 0;
`endif
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid),      32'd0);
    check("rst_in_ready",  32'(in_ready),       32'd1);
    check("rst_out_data",  32'(out_data),       32'd0);
    check("rst_corr",      32'(out_err_corr),   32'd0);
    check("rst_uncorr",    32'(out_err_uncorr), 32'd0);
    @(posedge clk);
    #1;
    check("rst_in_ready_hold", 32'(in_ready), 32'd1);
    reset = 1'b1;

    // Clean, single-bit (position 5 and overall parity bit) and double-bit words.
    single("clean_aa",  8'hAA, 4'hB, 1'b0, 1'b0);
    single("flip5_8a",  8'h8A, 4'hB, 1'b1, 1'b0);
    single("flip0_ab",  8'hAB, 4'hB, 1'b1, 1'b0);
    single("double_ca", 8'hCA, 4'hD, 1'b0, 1'b1);
`ifdef HAMM_ERR_CNT_EN
    check("cnt_uncorr_after_ca", 32'(cnt_uncorr), 32'd1);
`endif

    // Back-to-back stream with three cycles of backpressure.
    got_q.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = 8'h00;
    tick();
    in_code = 8'hAA;
    tick();
    in_code   = 8'h8A;
    out_ready = 1'b0;
    #1;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    check("bp_8a_accepted", 32'(accepted), 32'd1);
    drain();
    check("bp_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("bp_order0", 32'(got_q[0]), 32'h0);
      check("bp_order1", 32'(got_q[1]), 32'hB);
      check("bp_order2", 32'(got_q[2]), 32'hB);
    end

    // Reset asserted while a word is waiting at the output.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = 8'h8A;
    tick();
    in_valid = 1'b0;
    tick();
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data",  32'(out_data),  32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
`ifdef HAMM_ERR_CNT_EN
    check("mid_rst_cnt_corr",   32'(cnt_corr),   32'd0);
    check("mid_rst_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
    m_corr   = 0;
    m_uncorr = 0;
`endif
    exp_q.delete();
    hold_pending = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    single("post_rst_aa", 8'hAA, 4'hB, 1'b0, 1'b0);

`ifdef HAMM_ERR_CNT_EN
    // Saturation, then a clear coincident with a corrected handshake.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    repeat (5) single("sat_8a", 8'h8A, 4'hB, 1'b1, 1'b0);
    check("cnt_corr_saturated", 32'(cnt_corr), 32'd3);
    in_valid = 1'b1;
    in_code  = 8'h8A;
    tick();
    in_valid = 1'b0;
    tick();
    check("clr_out_valid", 32'(out_valid), 32'd1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("cnt_corr_cleared", 32'(cnt_corr), 32'd0);
`endif

    // Randomized traffic with 0, 1 or 2 injected bit errors and random stalls.
    for (int cyc = 0; cyc < 400; cyc++) begin
      d    = DATA_W'($urandom);
      nerr = int'($urandom_range(0, 2));
      b1   = int'($urandom_range(0, CW_W - 1));
      b2   = (b1 + 1 + int'($urandom_range(0, CW_W - 2))) % CW_W;
      mask = '0;
      if (nerr >= 1) mask[b1] = 1'b1;
      if (nerr == 2) mask[b2] = 1'b1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_code   = encode(d) ^ mask;
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef HAMM_ERR_CNT_EN
      clr_cnt = ($urandom_range(0, 49) == 0);
`endif
      tick();
    end
`ifdef HAMM_ERR_CNT_EN
    clr_cnt = 1'b0;
`endif
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
